cmult_accum: RTL and testbench

//   Complex accumulator directly downstream of cmult. Sums FRAME_LEN valid
//   Q-format products (pr, pi) into a wide accumulator, then saturates the

---
 rtl/cmult_accum.sv | 155 +++++++++++++++
 tb/tb_cmult_accum.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmult_accum.sv
// cmult_accum: frame accumulator for complex Q-format products.
// Sums FRAME_LEN accepted (pr, pi) samples into N+GUARD bit accumulators,
// saturates each frame sum to N bits and holds it in a valid/ready output
// register. An unconsumed result that gets overwritten sets the sticky ovf.
module cmult_accum #(
   parameter int Q         = 8,
   parameter int N         = 16,
   parameter int FRAME_LEN = 8,
   parameter int GUARD     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [N-1:0] pr,
   input  logic [N-1:0] pi,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [N-1:0] sr,
   output logic [N-1:0] si,
   output logic         sat_flag,
   output logic         ovf,
   output logic         busy
);

   localparam int AW = N + GUARD;
   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [AW-1:0] MAX_V    = {{(GUARD + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic [AW-1:0] MIN_V    = {{(GUARD + 1){1'b1}}, {(N - 1){1'b0}}};

   // Catch parameter sets where the guard bits cannot hold a full frame.
   if ((FRAME_LEN < 1) || (FRAME_LEN > (1 << GUARD)) || (Q >= N)) begin : g_param_check
      $error("cmult_accum: illegal parameter combination");
   end

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Clip a wide sum to N bits; MSB of the result reports whether it clipped.
   function automatic logic [N:0] saturate(input logic [AW-1:0] v);
      logic [N:0] res;
      if ($signed(v) > $signed(MAX_V)) begin
         res = {1'b1, MAX_V[N-1:0]};
      end else if ($signed(v) < $signed(MIN_V)) begin
         res = {1'b1, MIN_V[N-1:0]};
      end else begin
         res = {1'b0, v[N-1:0]};
      end
      return res;
   endfunction

   state_t         state_r;
   logic [AW-1:0]  acc_re_r;
   logic [AW-1:0]  acc_im_r;
   logic [CW-1:0]  count_r;

   logic           accept_s;
   logic           last_s;
   logic [AW-1:0]  sum_re_s;
   logic [AW-1:0]  sum_im_s;
   logic [N:0]     sat_re_s;
   logic [N:0]     sat_im_s;

   // Sample acceptance, running sums including the current sample, and clipping.
   always_comb begin
      accept_s = in_valid & ~clear;
      last_s   = accept_s & (count_r == LAST_CNT);
      sum_re_s = acc_re_r + {{GUARD{pr[N-1]}}, pr};
      sum_im_s = acc_im_r + {{GUARD{pi[N-1]}}, pi};
      sat_re_s = saturate(sum_re_s);
      sat_im_s = saturate(sum_im_s);
   end

   // Frame FSM, accumulators and the registered result/handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         acc_re_r  <= '0;
         acc_im_r  <= '0;
         count_r   <= '0;
         out_valid <= 1'b0;
         sr        <= '0;
         si        <= '0;
         sat_flag  <= 1'b0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // accumulation side: clear aborts, the last sample closes the frame
         if (clear) begin
            state_r  <= IDLE;
            acc_re_r <= '0;
            acc_im_r <= '0;
            count_r  <= '0;
            busy     <= 1'b0;
         end else if (accept_s) begin
            case (state_r)
               IDLE, ACCUM: begin
                  if (last_s) begin
                     state_r  <= IDLE;
                     acc_re_r <= '0;
                     acc_im_r <= '0;
                     count_r  <= '0;
                     busy     <= 1'b0;
                  end else begin
                     state_r  <= ACCUM;
                     acc_re_r <= sum_re_s;
                     acc_im_r <= sum_im_s;
                     count_r  <= count_r + ONE_CNT;
                     busy     <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  acc_re_r <= '0;
                  acc_im_r <= '0;
                  count_r  <= '0;
                  busy     <= 1'b0;
               end
            endcase
         end else begin
            state_r  <= state_r;
            acc_re_r <= acc_re_r;
            acc_im_r <= acc_im_r;
            count_r  <= count_r;
            busy     <= busy;
         end

         // result side: a new frame result wins over consumption of the old one
         if (last_s) begin
            sr        <= sat_re_s[N-1:0];
            si        <= sat_im_s[N-1:0];
            sat_flag  <= sat_re_s[N] | sat_im_s[N];
            out_valid <= 1'b1;
         end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
         end else begin
            out_valid <= out_valid;
         end

         // sticky overwrite flag, only clear releases it
         if (clear) begin
            ovf <= 1'b0;
         end else if (last_s & out_valid & ~out_ready) begin
            ovf <= 1'b1;
         end else begin
            ovf <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_cmult_accum.sv
// Bench for cmult_accum (Q8.8, N=16, FRAME_LEN=8): vector table, hand-written
// corner sequences and randomized traffic, all checked against a frame-level
// arithmetic reference model.
module tb_cmult_accum;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, out_ready;
   logic [15:0] pr, pi;
   logic        out_valid, sat_flag, ovf, busy;
   logic [15:0] sr, si;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // reference model state: integer frame sums and expected outputs
   int          m_acc_r, m_acc_i, m_cnt;
   logic        m_ov, m_sat, m_ovf;
   logic [15:0] m_r, m_i;

   always #5 clk = ~clk;

   cmult_accum #(.Q(8), .N(16), .FRAME_LEN(8), .GUARD(4)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
      .pr(pr), .pi(pi), .out_ready(out_ready), .out_valid(out_valid),
      .sr(sr), .si(si), .sat_flag(sat_flag), .ovf(ovf), .busy(busy)
   );

   function automatic logic [16:0] satm(input int v);
      logic [16:0] res;
      if (v > 32767)       res = {1'b1, 16'h7FFF};
      else if (v < -32768) res = {1'b1, 16'h8000};
      else                 res = {1'b0, v[15:0]};
      return res;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // one clock: drive inputs, advance the model on the edge, compare all outputs
   task automatic step(input logic r, input logic c, input logic iv,
                       input logic [15:0] p_r, input logic [15:0] p_i, input logic rdy);
      logic        loaded;
      logic [16:0] sa, sb;
      rst = r; clear = c; in_valid = iv; pr = p_r; pi = p_i; out_ready = rdy;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_acc_r = 0; m_acc_i = 0; m_cnt = 0;
         m_ov = 1'b0; m_r = 16'h0000; m_i = 16'h0000; m_sat = 1'b0; m_ovf = 1'b0;
      end else begin
         loaded = 1'b0;
         if (c) begin
            m_acc_r = 0; m_acc_i = 0; m_cnt = 0; m_ovf = 1'b0;
         end else if (iv) begin
            m_acc_r += int'($signed(p_r));
            m_acc_i += int'($signed(p_i));
            m_cnt++;
            if (m_cnt == 8) begin
               sa = satm(m_acc_r);
               sb = satm(m_acc_i);
               m_r = sa[15:0]; m_i = sb[15:0]; m_sat = sa[16] | sb[16];
               if (m_ov && !rdy) m_ovf = 1'b1;
               m_ov = 1'b1;
               loaded = 1'b1;
               m_acc_r = 0; m_acc_i = 0; m_cnt = 0;
            end
         end
         if (!loaded && m_ov && rdy) m_ov = 1'b0;
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("sr", {16'd0, sr}, {16'd0, m_r});
      chk("si", {16'd0, si}, {16'd0, m_i});
      chk("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
   endtask

   typedef struct {
      logic [15:0] vr, vi, esr, esi;
      logic        esat;
   } vec_t;

   vec_t tbl[6];
   int   t1, t2;
   logic [15:0] v1, v2;

   initial begin
      tbl[0] = '{16'h0080, 16'hFF80, 16'h0400, 16'hFC00, 1'b0};
      tbl[1] = '{16'h4000, 16'hC000, 16'h7FFF, 16'h8000, 1'b1};
      tbl[2] = '{16'h0100, 16'h0100, 16'h0800, 16'h0800, 1'b0};
      tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1};
      tbl[4] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0008, 1'b1};
      tbl[5] = '{16'h0FFF, 16'hF000, 16'h7FF8, 16'h8000, 1'b0};

      // reset state
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sr", {16'd0, sr}, 32'd0);

      // table vectors: 8 identical samples, result one cycle later, one cycle long
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, tbl[i].vr, tbl[i].vi, 1'b1);
            if (k == 6) chk("tbl_early", {31'd0, out_valid}, 32'd0);
         end
         chk("tbl_valid", {31'd0, out_valid}, 32'd1);
         chk("tbl_sr", {16'd0, sr}, {16'd0, tbl[i].esr});
         chk("tbl_si", {16'd0, si}, {16'd0, tbl[i].esi});
         chk("tbl_sat", {31'd0, sat_flag}, {31'd0, tbl[i].esat});
         step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
         chk("tbl_pulse", {31'd0, out_valid}, 32'd0);
      end

      // back-to-back frames, no bubble
      t1 = -1; t2 = -1; v1 = 16'h0000; v2 = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b0, 1'b1, (k < 8) ? 16'h0100 : 16'h0200,
              (k < 8) ? 16'h0100 : 16'h0200, 1'b1);
         if (out_valid) begin
            if (t1 < 0) begin t1 = cyc; v1 = sr; end
            else begin t2 = cyc; v2 = sr; end
         end
      end
      chk("b2b_gap", t2 - t1, 32'd8);
      chk("b2b_first", {16'd0, v1}, 32'h0800);
      chk("b2b_second", {16'd0, v2}, 32'h1000);
      chk("b2b_ovf", {31'd0, ovf}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

      // out_ready low across two frames: hold, overwrite, sticky ovf, clear
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b0);
      chk("hold_first", {16'd0, sr}, 32'h0800);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 1'b1, 16'h0200, 16'h0200, 1'b0);
         if (k < 7) chk("hold_stable", {16'd0, sr}, 32'h0800);
      end
      chk("ovw_sr", {16'd0, sr}, 32'h1000);
      chk("ovw_valid", {31'd0, out_valid}, 32'd1);
      chk("ovw_ovf", {31'd0, ovf}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("clr_ovf", {31'd0, ovf}, 32'd0);
      chk("clr_keeps_result", {16'd0, sr}, 32'h1000);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      chk("consumed", {31'd0, out_valid}, 32'd0);

      // partial frame aborted by clear with in_valid high
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b1);
      chk("partial_busy", {31'd0, busy}, 32'd1);
      step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0100, 1'b1);
      chk("clr_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b1);
      chk("after_clr_sr", {16'd0, sr}, 32'h0800);

      // reset mid-frame with a held result and then a clean frame
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 16'h0300, 16'h0300, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 16'h0300, 16'h0300, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'h0300, 16'h0300, 1'b0);
      chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
      chk("rstmid_sr", {16'd0, sr}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0100, 1'b1);
      chk("rstmid_frame", {16'd0, sr}, 32'h0800);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] a, b;
         if ($urandom_range(0, 1) == 0) begin
            a = 16'($urandom_range(0, 1023)) - 16'd512;
            b = 16'($urandom_range(0, 1023)) - 16'd512;
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 9) < 7), a, b, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
